// File: rtl/branch_control_unit.sv
// Branch condition evaluator with a registered taken decision.
// Fixed one-cycle latency and no backpressure.
module branch_control_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [2:0]      b_control,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    output logic            branch_sel,
    output logic            out_valid
);

    typedef enum logic [2:0] {
        BC_NEVER  = 3'b000,
        BC_BEQ    = 3'b001,
        BC_BNE    = 3'b010,
        BC_BLT    = 3'b011,
        BC_BGE    = 3'b100,
        BC_BLTU   = 3'b101,
        BC_BGEU   = 3'b110,
        BC_ALWAYS = 3'b111
    } bc_e;

    logic w_eq;
    logic w_lt;
    logic w_ltu;
    logic w_taken;
    logic r_branch_sel;
    logic r_out_valid;

    // Three shared comparators; every condition derives from these.
    always_comb begin
        w_eq  = (r1 == r2);
        w_lt  = ($signed(r1) < $signed(r2));
        w_ltu = (r1 < r2);
    end

    // Select the condition; unknown codes fall back to not-taken.
    always_comb begin
        w_taken = 1'b0;
        case (bc_e'(b_control))
            BC_NEVER:  w_taken = 1'b0;
            BC_BEQ:    w_taken = w_eq;
            BC_BNE:    w_taken = !w_eq;
            BC_BLT:    w_taken = w_lt;
            BC_BGE:    w_taken = !w_lt;
            BC_BLTU:   w_taken = w_ltu;
            BC_BGEU:   w_taken = !w_ltu;
            BC_ALWAYS: w_taken = 1'b1;
            default:   w_taken = 1'b0;
        endcase
    end

    // Register the decision; idle cycles and reset clear both outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch_sel <= 1'b0;
            r_out_valid  <= 1'b0;
        end else if (in_valid) begin
            r_branch_sel <= w_taken;
            r_out_valid  <= 1'b1;
        end else begin
            r_branch_sel <= 1'b0;
            r_out_valid  <= 1'b0;
        end
    end

    assign branch_sel = r_branch_sel;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed testbench for branch_control_unit.
// Hand-computed expectations for each branch request.
module tb_branch_control_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  b_control;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        branch_sel;
    logic        out_valid;

    int n_checks;
    int n_fail;

    branch_control_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .b_control  (b_control),
        .r1         (r1),
        .r2         (r2),
        .branch_sel (branch_sel),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Present one request, wait for the capturing edge, check both outputs.
    task automatic req(input string tag, input logic v, input logic [2:0] bc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic exp_sel, input logic exp_vld);
        @(negedge clk);
        in_valid  = v;
        b_control = bc;
        r1        = a;
        r2        = b;
        @(posedge clk);
        #1;
        check({tag, ".sel"}, branch_sel, exp_sel);
        check({tag, ".vld"}, out_valid, exp_vld);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        b_control = 3'b111;
        r1        = '0;
        r2        = '0;
        @(posedge clk);
        #1;
        check("reset.sel", branch_sel, 1'b0);
        check("reset.vld", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands
        req("beq_eq",  1, 3'b001, 32'hF000_0000, 32'hF000_0000, 1, 1);
        req("bne_eq",  1, 3'b010, 32'hF000_0000, 32'hF000_0000, 0, 1);
        req("blt_eq",  1, 3'b011, 32'hF000_0000, 32'hF000_0000, 0, 1);
        req("bge_eq",  1, 3'b100, 32'hF000_0000, 32'hF000_0000, 1, 1);
        req("bltu_eq", 1, 3'b101, 32'hF000_0000, 32'hF000_0000, 0, 1);
        req("bgeu_eq", 1, 3'b110, 32'hF000_0000, 32'hF000_0000, 1, 1);

        // Signed compare, r1 just below r2
        req("bne_s",   1, 3'b010, 32'hF000_0000, 32'hF000_0001, 1, 1);
        req("blt_s",   1, 3'b011, 32'hF000_0000, 32'hF000_0001, 1, 1);
        req("bge_s",   1, 3'b100, 32'hF000_0000, 32'hF000_0001, 0, 1);
        req("jal_s",   1, 3'b111, 32'hF000_0000, 32'hF000_0001, 1, 1);
        req("beq_ne",  1, 3'b001, 32'hF000_0000, 32'hF000_0001, 0, 1);

        // Signed vs unsigned, both negative
        req("bge_su",  1, 3'b100, 32'hF000_0000, 32'hFFFF_FFFF, 0, 1);
        req("bltu_su", 1, 3'b101, 32'hF000_0000, 32'hFFFF_FFFF, 1, 1);
        req("bgeu_su", 1, 3'b110, 32'hF000_0000, 32'hFFFF_FFFF, 0, 1);
        req("blt_su",  1, 3'b011, 32'hF000_0000, 32'hFFFF_FFFF, 1, 1);

        // Sign boundary
        req("blt_b",   1, 3'b011, 32'h8000_0000, 32'h7FFF_FFFF, 1, 1);
        req("bltu_b",  1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1);
        req("never_b", 1, 3'b000, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1);
        req("bge_b",   1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1);
        req("bgeu_b",  1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1, 1);
        req("bge_rev", 1, 3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 1, 1);
        req("never_eq",1, 3'b000, 32'h1234_5678, 32'h1234_5678, 0, 1);

        // Valid gating and back-to-back traffic
        req("idle",    0, 3'b111, 32'h0, 32'h0, 0, 0);
        req("b2b0",    1, 3'b111, 32'h0, 32'h1, 1, 1);
        req("b2b1",    1, 3'b000, 32'h0, 32'h1, 0, 1);
        req("b2b2",    1, 3'b101, 32'h0, 32'h1, 1, 1);
        req("idle2",   0, 3'b001, 32'h5, 32'h5, 0, 0);

        // Reset pulse during valid jump traffic
        req("pre_rst", 1, 3'b111, 32'h0, 32'h0, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.sel", branch_sel, 1'b0);
        check("midrst.vld", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req("post_rst",  1, 3'b111, 32'h0, 32'h0, 1, 1);
        req("post_rst2", 1, 3'b010, 32'h3, 32'h3, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_control_unit.md
BRANCH_CONTROL_UNIT -- requirements
Module: branch_control

Interface
REQ-001 Parameter: XLEN, default 32, operand width in bits.
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: in_valid  input  1  high when b_control, r1 and r2 carry a branch request this cycle.
REQ-005 Port: b_control  input  3  branch condition select, encoded per REQ-010.
REQ-006 Port: r1  input  XLEN  first source operand (rs1 value).
REQ-007 Port: r2  input  XLEN  second source operand (rs2 value).
REQ-008 Port: branch_sel  output  1  registered branch-taken decision; 1 selects the branch target for the PC.
REQ-009 Port: out_valid  output  1  registered; high when branch_sel reflects a request accepted on the previous edge.

Function
REQ-010 b_control encoding SHALL be:
  - 000 never taken
  - 001 BEQ (r1 == r2)
  - 010 BNE (r1 != r2)
  - 011 BLT (signed r1 < r2)
  - 100 BGE (signed r1 >= r2)
  - 101 BLTU (unsigned r1 < r2)
  - 110 BGEU (unsigned r1 >= r2)
  - 111 always taken (unconditional jump)
REQ-011 Comparisons SHALL be combinational over the full XLEN bits: one equality, one signed less-than and one unsigned less-than, shared by all conditions.
REQ-012 Signed compare SHALL treat bit XLEN-1 as a two's-complement sign bit; unsigned compare SHALL treat operands as magnitudes.
REQ-013 On each rising clk edge with rst_n=1 and in_valid=1, the condition result SHALL be registered into branch_sel, and out_valid SHALL be set to 1.
REQ-014 The decision SHALL appear one cycle after acceptance (fixed latency 1), with no stall or backpressure; a new request MAY be accepted every cycle.
REQ-015 On an edge with rst_n=1 and in_valid=0, branch_sel SHALL become 0 and out_valid SHALL become 0.
REQ-016 Code 000 SHALL yield branch_sel=0 and code 111 SHALL yield branch_sel=1 regardless of operands; both still set out_valid=1 when in_valid=1.
REQ-017 X/undefined b_control MUST NOT be produced by a correct source; the implementation SHALL use a default branch mapping to not-taken.
REQ-018 Edge cases:
  - equal operands SHALL give BLT=0, BGE=1, BLTU=0, BGEU=1
  - 0x80000000 vs 0x7FFFFFFF SHALL give BLT=1, BLTU=0

Reset
REQ-019 When rst_n=0 at a rising clk edge, branch_sel and out_valid SHALL be 0 after that edge, regardless of in_valid.
REQ-020 Reset SHALL discard any in-flight decision; the first valid output after release follows the first accepted request by one cycle.
REQ-021 The block SHALL hold no other state.

Verification
REQ-022 Scenario (equal operands): r1=r2=0xF0000000, in_valid=1, then b_control=001 -> branch_sel=1 next cycle; then b_control=010 -> branch_sel=0.
REQ-023 Scenario (signed compare): r1=0xF0000000, r2=0xF0000001:
  - b_control 010 -> branch_sel=1
  - b_control 011 -> branch_sel=1
  - b_control 100 -> branch_sel=0
  - b_control 111 -> branch_sel=1
REQ-024 Scenario (signed vs unsigned): r1=0xF0000000, r2=0xFFFFFFFF:
  - b_control 100 -> branch_sel=0
  - b_control 101 -> branch_sel=1
  - b_control 110 -> branch_sel=0
  - b_control 011 -> branch_sel=1
REQ-025 Scenario (sign boundary): r1=0x80000000, r2=0x7FFFFFFF:
  - b_control 011 -> branch_sel=1
  - b_control 101 -> branch_sel=0
  - b_control 000 -> branch_sel=0
REQ-026 Scenario (valid gating): in_valid=0 with b_control=111 -> branch_sel=0 and out_valid=0 next cycle; back-to-back valid requests SHALL give one decision per cycle.
REQ-027 Scenario (reset mid-operation): pulse rst_n=0 for one edge during valid 111 traffic -> branch_sel=0 and out_valid=0 after that edge, then resume with 1-cycle latency.
